// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 receive path and the mouse control FSM.
//   - whole-frame constants (ACK, EN_REPORTING) and data-byte constants (BAT_OK, MOUSE_ID,
//     RESET_CMD)
//   - field indices inside an 11-bit frame: [0]=start, [8:1]=data (LSB at 1), [9]=odd parity,
//     [10]=stop
//   - ps2_rx_frame state encoding and the frame validity rule
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;

  // Field positions inside a received frame.
  localparam int unsigned START    = 0;
  localparam int unsigned DATA_LSB = 1;
  localparam int unsigned DATA_MSB = 8;
  localparam int unsigned PARITY   = 9;
  localparam int unsigned STOP     = 10;

  // Complete frames as they appear on rx_data.
  localparam logic [FRAME_BITS-1:0] ACK          = 11'b11111110100;  // 0xFA
  localparam logic [FRAME_BITS-1:0] EN_REPORTING = 11'b10111101000;  // 0xF4

  // Data bytes.
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] MOUSE_ID  = 8'h00;
  localparam logic [7:0] RESET_CMD = 8'hFF;

  // rx_data value before the first good frame; an alternating pattern is easy to spot.
  localparam logic [FRAME_BITS-1:0] RX_RESET_VALUE = 11'b10101010101;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck
  } rx_state_e;

  // Start low, stop high, and the data bits plus parity bit hold an odd number of ones.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[START] == 1'b0) && (f[STOP] == 1'b1) && ((^f[PARITY:DATA_LSB]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_input_sync_filter.sv
// ps2_input_sync_filter: conditions the raw open-collector PS/2 pins for the clk_25MHz domain.
//   clk_25MHz    in   system clock
//   reset        in   asynchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock pin (asynchronous)
//   ps2_data     in   raw PS/2 data pin (asynchronous)
//   filtered_clk out  ps2_clk after synchronizing and glitch filtering (idles high)
//   data_s       out  synchronized ps2_data
//   fall_strobe  out  one-cycle pulse after each 1->0 transition of filtered_clk
// The strobe follows a pin falling edge by 2 (sync) + FILTER_LEN + 1 cycles.
module ps2_input_sync_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic filtered_clk,
  output logic data_s,
  output logic fall_strobe
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_q;
  logic             filt_prev_q;
  logic             strobe_q;
  logic             clk_s;

  assign clk_s = clk_sync_q[1];

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      // Both lines idle high on the bus, so the synchronizers start there too.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};

      // Count consecutive samples that disagree with the filtered level; any agreeing
      // sample restarts the count, so a glitch shorter than FILTER_LEN never gets through.
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltLast) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end

      filt_prev_q <= filt_q;
      strobe_q    <= filt_prev_q & ~filt_q;
    end
  end

  assign filtered_clk = filt_q;
  assign data_s       = data_sync_q[1];
  assign fall_strobe  = strobe_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 receive stage. Assembles 11-bit device-to-host frames and hands them
// to the mouse control FSM.
//   clk_25MHz      in   system clock, 25 MHz
//   reset          in   asynchronous, active-high reset
//   ps2_clk        in   raw PS/2 clock pin (asynchronous)
//   ps2_data       in   raw PS/2 data pin (asynchronous)
//   rx_data        out  last good frame ([0]=start ... [10]=stop), held until the next one
//   data_available out  one-cycle pulse when rx_data is updated
//   err            out  one-cycle pulse on a bad or timed-out frame
//   busy           out  high while a frame is being received and checked
// data_available rises two cycles after the cycle carrying the 11th edge strobe.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk_25MHz,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  data_available,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast   = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LastBit  = 4'(FRAME_BITS - 1);

  logic                  filtered_clk;
  logic                  data_s;
  logic                  fall_strobe;
  logic                  unused_filtered_clk;

  rx_state_e             state_q;
  logic [3:0]            bit_cnt_q;
  logic [ToW-1:0]        to_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_in;

  ps2_input_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk_25MHz    (clk_25MHz),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .filtered_clk (filtered_clk),
    .data_s       (data_s),
    .fall_strobe  (fall_strobe)
  );

  // The filtered level itself is only needed by the strobe generator.
  assign unused_filtered_clk = filtered_clk;

  // LSB is sent first, so bits enter at the top; after 11 bits the start bit lands in [0].
  assign shift_in = {data_s, shift_q[FRAME_BITS-1:1]};

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      shift_q        <= '0;
      rx_data        <= RX_RESET_VALUE;
      data_available <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_available <= 1'b0;
      err            <= 1'b0;

      unique case (state_q)
        StIdle: begin
          busy <= 1'b0;
          // A strobe with data high is not a start bit and is dropped.
          if (fall_strobe && !data_s) begin
            shift_q   <= shift_in;
            bit_cnt_q <= 4'd1;
            to_cnt_q  <= '0;
            busy      <= 1'b1;
            state_q   <= StRecv;
          end
        end

        StRecv: begin
          if (fall_strobe) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            to_cnt_q  <= '0;
            if (bit_cnt_q == LastBit) begin
              state_q <= StCheck;
            end
          end else if (to_cnt_q == ToLast) begin
            // Device stopped clocking mid-frame: abandon it.
            err       <= 1'b1;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end

        StCheck: begin
          // Any strobe arriving in this single cycle is ignored.
          if (frame_ok(shift_q)) begin
            rx_data        <= shift_q;
            data_available <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          bit_cnt_q <= '0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end

        default: begin
          bit_cnt_q <= '0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Testbench for ps2_rx_frame. Stimulus tasks push the expected outcome of each frame into a
// queue; an independent monitor pops and compares whenever data_available or err pulses.
module tb_ps2_rx_frame;

  localparam int SLOW_HALF = 1000;  // 12.5 kHz PS/2 clock at 25 MHz
  localparam int FAST_HALF = 100;
  localparam logic [10:0] RESET_RX = 11'b10101010101;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] rx_data;
  logic        data_available;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit          is_err;
    logic [10:0] rx;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] model_rx;

  always #20 clk_25MHz = ~clk_25MHz;

  ps2_rx_frame dut (
    .clk_25MHz      (clk_25MHz),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .rx_data        (rx_data),
    .data_available (data_available),
    .err            (err),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_25MHz);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1, optionally corrupted.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0);
    if (bad_par) par = ~par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic push_expect(input bit good, input logic [10:0] f);
    exp_t e;
    if (good) model_rx = f;
    e.is_err = !good;
    e.rx     = model_rx;
    exp_q.push_back(e);
  endtask

  // Drive bits f[0..nbits-1]; data changes mid high phase, sampled at the falling edge.
  // glitch_mask bit i adds a 4-cycle low pulse on ps2_clk in the high phase after bit i.
  task automatic send_bits(input logic [10:0] f, input int nbits, input int half,
                           input logic [10:0] glitch_mask, input bit check_busy);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cycles(half / 2);
      ps2_clk = 1'b0;
      if (check_busy && i == 1) begin
        wait_cycles(half / 2);
        check("busy_mid_frame", busy, 1);
        wait_cycles(half - half / 2);
      end else begin
        wait_cycles(half);
      end
      ps2_clk = 1'b1;
      if (glitch_mask[i]) begin
        wait_cycles(half / 4);
        ps2_clk = 1'b0;
        wait_cycles(4);
        ps2_clk = 1'b1;
        wait_cycles(half / 2 - half / 4 - 4);
      end else begin
        wait_cycles(half / 2);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input logic [10:0] glitch_mask);
    logic [10:0] f;
    f = make_frame(b, bad_par, bad_stop);
    push_expect(!bad_par && !bad_stop, f);
    send_bits(f, 11, half, glitch_mask, 1'b1);
    wait_cycles(50);
    check("busy_after_frame", busy, 0);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin : monitor
    forever begin
      @(negedge clk_25MHz);
      if (!reset) begin
        if (data_available && err) begin
          checks++;
          errors++;
          $display("FAIL pulse_overlap: data_available and err both high (t=%0t)", $time);
        end else if (data_available || err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got err=%0b da=%0b rx=%0h, expected no pulse",
                     err, data_available, rx_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_is_err", err, e.is_err);
            check("rx_data", rx_data, e.rx);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [10:0] f;
    logic [10:0] tail;
    int          r;

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_rx = RESET_RX;
    wait_cycles(5);
    check("reset_rx_data", rx_data, RESET_RX);
    check("reset_da", data_available, 0);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    wait_cycles(20);
    check("idle_busy", busy, 0);

    // ACK at the nominal 12.5 kHz rate.
    send_frame(8'hFA, 1'b0, 1'b0, SLOW_HALF, 11'd0);

    // Back-to-back BAT_OK and mouse ID.
    send_frame(8'hAA, 1'b0, 1'b0, FAST_HALF, 11'd0);
    send_frame(8'h00, 1'b0, 1'b0, FAST_HALF, 11'd0);

    // Bad parity, then bad stop followed by a good frame.
    send_frame(8'hFA, 1'b1, 1'b0, FAST_HALF, 11'd0);
    send_frame(8'hFA, 1'b0, 1'b1, FAST_HALF, 11'd0);
    send_frame(8'hAA, 1'b0, 1'b0, FAST_HALF, 11'd0);

    // Timeout: five bits, then the clock stays high.
    f = make_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    push_expect(1'b0, f);
    send_bits(f, 5, FAST_HALF, 11'd0, 1'b1);
    wait_cycles(4400);
    check("busy_before_timeout", busy, 1);
    wait_cycles(700);
    check("busy_after_timeout", busy, 0);
    check("timeout_err_seen", exp_q.size(), 0);
    send_frame(8'hF4, 1'b0, 1'b0, FAST_HALF, 11'd0);

    // Short low glitches on ps2_clk inside a frame.
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, FAST_HALF, 11'b00100100100);

    // Reset after bit 6 of a frame.
    f = make_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_bits(f, 6, FAST_HALF, 11'd0, 1'b1);
    reset = 1'b1;
    #5;
    check("midreset_rx_data", rx_data, RESET_RX);
    check("midreset_da", data_available, 0);
    check("midreset_err", err, 0);
    check("midreset_busy", busy, 0);
    wait_cycles(3);
    reset    = 1'b0;
    model_rx = RESET_RX;
    // The remaining five bits can only start a frame that later times out.
    tail = f >> 6;
    if (tail[4:0] != 5'b11111) push_expect(1'b0, 11'd0);
    send_bits(tail, 5, FAST_HALF, 11'd0, 1'b0);
    wait_cycles(5300);
    check("after_reset_tail", exp_q.size(), 0);
    check("after_reset_busy", busy, 0);

    // Random frames with occasional parity or stop corruption.
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 9);
      send_frame(8'($urandom_range(0, 255)), r < 2, r == 2, FAST_HALF, 11'd0);
    end

    wait_cycles(200);
    check("all_expected_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
